compare_block: RTL and testbench

//   Read-side checker for the AMM memory tester. Armed by the transmitter with a cmp_struct_t

---
 rtl/rtl_settings_pkg.sv | 37 +++
 rtl/rnd_data_gen.sv | 28 ++
 rtl/compare_block.sv | 178 +++++++++++++++++
 tb/tb_compare_block.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/rtl_settings_pkg.sv
// Shared sizing constants and types for the AMM memory tester.
// Holds the compare descriptor, the data-mode enum and the compare FSM states.
package rtl_settings_pkg;

    localparam int AMM_DATA_W  = 64;
    localparam int DATA_B_W    = AMM_DATA_W / 8;
    localparam int ADDR_B_W    = $clog2(DATA_B_W);
    localparam int AMM_BURST_W = 4;
    localparam int ADDR_W      = 32;
    localparam     ADDR_TYPE   = "BYTE";

    typedef enum logic {
        FIX_DATA = 1'b0,
        RND_DATA = 1'b1
    } data_mode_t;

    typedef struct packed {
        logic [ADDR_W-1:0]      start_addr;
        logic [AMM_BURST_W-2:0] words_count;
        logic [ADDR_B_W-1:0]    start_off;
        logic [ADDR_B_W-1:0]    end_off;
        logic [7:0]             data_ptrn;
        data_mode_t             data_mode;
    } cmp_struct_t;

    typedef enum logic [1:0] {
        CMP_IDLE  = 2'd0,
        CMP_CHECK = 2'd1,
        CMP_DRAIN = 2'd2
    } cmp_state_t;

    // One step of the 8-bit pattern LFSR (taps 6,1,0); transmitter uses the same step.
    function automatic logic [7:0] lfsr_next(input logic [7:0] value);
        return {value[6:0], value[6] ^ value[1] ^ value[0]};
    endfunction

endpackage

// File: rtl/rnd_data_gen.sv
// Byte pattern generator: loads a seed, then steps the shared LFSR on advance.
// Identical stepping on the transmit and compare side keeps both bit-exact.
module rnd_data_gen
    import rtl_settings_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [7:0] seed_i,
    input  logic       advance_i,
    output logic [7:0] data_o
);

    logic [7:0] data_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_reg <= '0;
        end else if (load_i) begin
            data_reg <= seed_i;
        end else if (advance_i) begin
            data_reg <= lfsr_next(data_reg);
        end
    end

    assign data_o = data_reg;

endmodule

// File: rtl/compare_block.sv
// Read-side checker: regenerates the written burst pattern and compares read beats byte-masked.
// Optional first-error capture ports are built when COMPARE_ERR_CAPTURE_EN is defined.
module compare_block
    import rtl_settings_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmp_en_i,
    input  cmp_struct_t           cmp_struct_i,
    input  logic                  readdatavalid_i,
    input  logic [AMM_DATA_W-1:0] readdata_i,
    output logic                  cmp_error_o,
    output logic                  cmp_busy_o
`ifdef COMPARE_ERR_CAPTURE_EN
    ,
    output logic [ADDR_W-1:0]     err_addr_o,
    output logic [AMM_DATA_W-1:0] err_data_o,
    output logic [AMM_DATA_W-1:0] err_exp_o
`endif
);

    cmp_state_t             state_reg;
    logic [AMM_BURST_W-2:0] beats_left_reg;
    logic [AMM_BURST_W-2:0] beat_idx_reg;
    logic [ADDR_B_W-1:0]    start_off_reg;
    logic [ADDR_B_W-1:0]    end_off_reg;
    data_mode_t             mode_reg;
    logic                   cmp_error_reg;
    logic                   busy_reg;

    logic                   arm;
    logic                   beat_check;
    logic                   first_beat;
    logic                   last_beat;
    logic [7:0]             exp_byte;
    logic [DATA_B_W-1:0]    byte_mask;
    logic [DATA_B_W-1:0]    byte_bad;
    logic                   mismatch;

    assign arm        = (state_reg == CMP_IDLE) && cmp_en_i;
    assign beat_check = (state_reg == CMP_CHECK) && readdatavalid_i;
    assign first_beat = (beat_idx_reg == '0);
    assign last_beat  = (beats_left_reg == '0);

    rnd_data_gen u_rnd_data_gen (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (arm),
        .seed_i    (cmp_struct_i.data_ptrn),
        .advance_i (beat_check && (mode_reg == RND_DATA)),
        .data_o    (exp_byte)
    );

    generate
        if (ADDR_TYPE == "BYTE") begin : g_byte_mask
            for (genvar gi = 0; gi < DATA_B_W; gi++) begin : g_lane
                localparam logic [ADDR_B_W-1:0] LANE = ADDR_B_W'(gi);
                assign byte_mask[gi] = (!first_beat || (LANE >= start_off_reg)) &&
                                       (!last_beat  || (LANE <= end_off_reg));
            end
        end else begin : g_word_mask
            logic unused_offsets;
            assign unused_offsets = ^{start_off_reg, end_off_reg, first_beat};
            assign byte_mask      = '1;
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < DATA_B_W; gi++) begin : g_cmp
            assign byte_bad[gi] = byte_mask[gi] && (readdata_i[8*gi +: 8] != exp_byte);
        end
    endgenerate

    assign mismatch = |byte_bad;

    // A mismatch mid-burst moves to DRAIN so the rest of the burst is swallowed without a second pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg      <= CMP_IDLE;
            beats_left_reg <= '0;
            beat_idx_reg   <= '0;
            start_off_reg  <= '0;
            end_off_reg    <= '0;
            mode_reg       <= FIX_DATA;
            cmp_error_reg  <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            cmp_error_reg <= 1'b0;
            case (state_reg)
                CMP_IDLE: begin
                    if (cmp_en_i) begin
                        state_reg      <= CMP_CHECK;
                        busy_reg       <= 1'b1;
                        beats_left_reg <= cmp_struct_i.words_count;
                        beat_idx_reg   <= '0;
                        start_off_reg  <= cmp_struct_i.start_off;
                        end_off_reg    <= cmp_struct_i.end_off;
                        mode_reg       <= cmp_struct_i.data_mode;
                    end
                end
                CMP_CHECK: begin
                    if (readdatavalid_i) begin
                        beats_left_reg <= beats_left_reg - 1'b1;
                        beat_idx_reg   <= beat_idx_reg + 1'b1;
                        if (mismatch) begin
                            cmp_error_reg <= 1'b1;
                        end
                        if (last_beat) begin
                            state_reg <= CMP_IDLE;
                            busy_reg  <= 1'b0;
                        end else if (mismatch) begin
                            state_reg <= CMP_DRAIN;
                        end
                    end
                end
                CMP_DRAIN: begin
                    if (readdatavalid_i) begin
                        beats_left_reg <= beats_left_reg - 1'b1;
                        beat_idx_reg   <= beat_idx_reg + 1'b1;
                        if (last_beat) begin
                            state_reg <= CMP_IDLE;
                            busy_reg  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_reg <= CMP_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign cmp_error_o = cmp_error_reg;
    assign cmp_busy_o  = busy_reg;

`ifdef COMPARE_ERR_CAPTURE_EN
    localparam int ADDR_STEP_SH = (ADDR_TYPE == "BYTE") ? ADDR_B_W : 0;

    logic [ADDR_W-1:0]     start_addr_reg;
    logic                  err_seen_reg;
    logic [ADDR_W-1:0]     err_addr_reg;
    logic [AMM_DATA_W-1:0] err_data_reg;
    logic [AMM_DATA_W-1:0] err_exp_reg;
    logic [ADDR_W-1:0]     beat_addr_off;

    assign beat_addr_off = ADDR_W'(beat_idx_reg) << ADDR_STEP_SH;

    // Loads on the same edge that raises cmp_error_o; only the first error since reset sticks.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            start_addr_reg <= '0;
            err_seen_reg   <= 1'b0;
            err_addr_reg   <= '0;
            err_data_reg   <= '0;
            err_exp_reg    <= '0;
        end else begin
            if (arm) begin
                start_addr_reg <= cmp_struct_i.start_addr;
            end
            if (beat_check && mismatch && !err_seen_reg) begin
                err_seen_reg <= 1'b1;
                err_addr_reg <= start_addr_reg + beat_addr_off;
                err_data_reg <= readdata_i;
                err_exp_reg  <= {DATA_B_W{exp_byte}};
            end
        end
    end

    assign err_addr_o = err_addr_reg;
    assign err_data_o = err_data_reg;
    assign err_exp_o  = err_exp_reg;
`else
    logic unused_start_addr;
    assign unused_start_addr = ^cmp_struct_i.start_addr;
`endif

endmodule

// File: tb/tb_compare_block.sv
// Scoreboard bench for compare_block: per-beat expected pulse pushed at drive, popped after the edge.
module tb_compare_block;
    import rtl_settings_pkg::*;

    logic                  clk_i = 1'b0;
    logic                  rst_i;
    logic                  cmp_en_i;
    cmp_struct_t           cmp_struct_i;
    logic                  readdatavalid_i;
    logic [AMM_DATA_W-1:0] readdata_i;
    logic                  cmp_error_o;
    logic                  cmp_busy_o;
`ifdef COMPARE_ERR_CAPTURE_EN
    logic [ADDR_W-1:0]     err_addr_o;
    logic [AMM_DATA_W-1:0] err_data_o;
    logic [AMM_DATA_W-1:0] err_exp_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit exp_q[$];

    always #5 clk_i = ~clk_i;

    compare_block dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .cmp_en_i        (cmp_en_i),
        .cmp_struct_i    (cmp_struct_i),
        .readdatavalid_i (readdatavalid_i),
        .readdata_i      (readdata_i),
        .cmp_error_o     (cmp_error_o),
        .cmp_busy_o      (cmp_busy_o)
`ifdef COMPARE_ERR_CAPTURE_EN
        ,
        .err_addr_o      (err_addr_o),
        .err_data_o      (err_data_o),
        .err_exp_o       (err_exp_o)
`endif
    );

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] lfsr_f(input logic [7:0] v);
        return {v[6:0], v[6] ^ v[1] ^ v[0]};
    endfunction

    function automatic logic [63:0] rep(input logic [7:0] b);
        return {8{b}};
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] good, input logic [63:0] bad,
                                          input logic [7:0] keep);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = keep[i] ? good[8*i +: 8] : bad[8*i +: 8];
        return r;
    endfunction

    // Monitor: every beat seen at an edge owes one scoreboard entry; otherwise no pulse allowed.
    always @(posedge clk_i) begin : monitor
        logic beat_seen;
        bit   exp_err;
        beat_seen = readdatavalid_i;
        #1;
        if (beat_seen) begin
            if (exp_q.size() == 0) begin
                check_value("sb_underflow", 64'd1, 64'd0);
            end else begin
                exp_err = exp_q.pop_front();
                check_value("cmp_error_beat", 64'(cmp_error_o), 64'(exp_err));
            end
        end else begin
            check_value("cmp_error_idle", 64'(cmp_error_o), 64'd0);
        end
    end

    task automatic arm(input logic [31:0] addr, input int wc, input int so, input int eo,
                       input logic [7:0] ptrn, input data_mode_t mode);
        cmp_struct_i.start_addr  = addr;
        cmp_struct_i.words_count = 3'(wc);
        cmp_struct_i.start_off   = 3'(so);
        cmp_struct_i.end_off     = 3'(eo);
        cmp_struct_i.data_ptrn   = ptrn;
        cmp_struct_i.data_mode   = mode;
        cmp_en_i = 1'b1;
        $display("arm addr=%h wc=%0d off=%0d/%0d ptrn=%h mode=%0d", addr, wc, so, eo, ptrn, mode);
        @(negedge clk_i);
        cmp_en_i = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] data, input bit exp_err);
        exp_q.push_back(exp_err);
        readdatavalid_i = 1'b1;
        readdata_i      = data;
        $display("beat data=%h exp_err=%0d", data, exp_err);
        @(negedge clk_i);
        readdatavalid_i = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0]  e;
        logic [63:0] d;
        rst_i           = 1'b1;
        cmp_en_i        = 1'b0;
        cmp_struct_i    = '0;
        readdatavalid_i = 1'b0;
        readdata_i      = '0;
        repeat (3) @(negedge clk_i);
        check_value("reset_busy", 64'(cmp_busy_o), 64'd0);
        check_value("reset_error", 64'(cmp_error_o), 64'd0);
`ifdef COMPARE_ERR_CAPTURE_EN
        check_value("reset_err_addr", 64'(err_addr_o), 64'd0);
        check_value("reset_err_data", err_data_o, 64'd0);
`endif
        rst_i = 1'b0;
        @(negedge clk_i);

        // 1: fixed pattern, 4 beats
        arm(32'h1000, 3, 0, 7, 8'hA5, FIX_DATA);
        check_value("t1_busy_armed", 64'(cmp_busy_o), 64'd1);
        for (int k = 0; k < 4; k++) begin
            send_beat(rep(8'hA5), 1'b0);
            check_value("t1_busy", 64'(cmp_busy_o), (k < 3) ? 64'd1 : 64'd0);
        end

        // 2: random pattern clean, then corrupted beat 1
        arm(32'h2000, 2, 0, 7, 8'hFF, RND_DATA);
        e = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            send_beat(rep(e), 1'b0);
            e = lfsr_f(e);
        end
        check_value("t2_busy_done", 64'(cmp_busy_o), 64'd0);
        arm(32'h2000, 2, 0, 7, 8'hFF, RND_DATA);
        send_beat(rep(8'hFF), 1'b0);
        d = rep(lfsr_f(8'hFF)) ^ 64'h1;
        send_beat(d, 1'b1);
        check_value("t2_busy_drain", 64'(cmp_busy_o), 64'd1);
        send_beat(64'hDEAD_BEEF_0000_1111, 1'b0);
        check_value("t2_busy_end", 64'(cmp_busy_o), 64'd0);
`ifdef COMPARE_ERR_CAPTURE_EN
        check_value("t2_err_addr", 64'(err_addr_o), 64'h2008);
        check_value("t2_err_data", err_data_o, d);
        check_value("t2_err_exp", err_exp_o, rep(lfsr_f(8'hFF)));
`endif

        // 3: masked edges; garbage outside the window, then a flip inside it
        arm(32'h3000, 1, 5, 2, 8'h3C, FIX_DATA);
        send_beat(merge(rep(8'h3C), 64'h0123_4567_89AB_CDEF, 8'b1110_0000), 1'b0);
        send_beat(merge(rep(8'h3C), 64'hFEDC_BA98_7654_3210, 8'b0000_0111), 1'b0);
        check_value("t3_busy_done", 64'(cmp_busy_o), 64'd0);
        arm(32'h3000, 1, 5, 2, 8'h3C, FIX_DATA);
        send_beat(merge(rep(8'h3C), 64'h0123_4567_89AB_CDEF, 8'b1110_0000) ^ (64'h1 << 40), 1'b1);
        send_beat(rep(8'h3C), 1'b0);
`ifdef COMPARE_ERR_CAPTURE_EN
        check_value("t3_err_addr_kept", 64'(err_addr_o), 64'h2008);
`endif

        // 4: single beat, bytes 2..4 only
        arm(32'h4000, 0, 2, 4, 8'hC3, RND_DATA);
        send_beat(merge(rep(8'hC3), 64'hFFFF_FFFF_FFFF_FFFF, 8'b0001_1100), 1'b0);
        check_value("t4_busy_done", 64'(cmp_busy_o), 64'd0);
        arm(32'h4000, 0, 2, 4, 8'hC3, RND_DATA);
        send_beat(rep(8'hC3) ^ (64'h80 << 32), 1'b1);
        check_value("t4_busy_err", 64'(cmp_busy_o), 64'd0);
        arm(32'h4000, 0, 2, 4, 8'hC3, RND_DATA);
        send_beat(rep(8'hC3) ^ (64'h80 << 40), 1'b0);

        // 5: robustness
        send_beat(64'h1234_5678_9ABC_DEF0, 1'b0);
        check_value("t5_idle_busy", 64'(cmp_busy_o), 64'd0);
        arm(32'h5000, 1, 0, 7, 8'h11, FIX_DATA);
        send_beat(rep(8'h11), 1'b0);
        arm(32'h5800, 5, 0, 7, 8'h22, FIX_DATA);
        send_beat(rep(8'h11), 1'b0);
        check_value("t5_rearm_ignored", 64'(cmp_busy_o), 64'd0);
        arm(32'h6000, 3, 0, 7, 8'h77, FIX_DATA);
        send_beat(rep(8'h77), 1'b0);
        rst_i = 1'b1;
        send_beat(64'h0, 1'b0);
        check_value("t5_rst_busy", 64'(cmp_busy_o), 64'd0);
        check_value("t5_rst_error", 64'(cmp_error_o), 64'd0);
`ifdef COMPARE_ERR_CAPTURE_EN
        check_value("t5_rst_err_addr", 64'(err_addr_o), 64'd0);
`endif
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        // 6: max burst, clean then with the last beat corrupted
        arm(32'h7000, 7, 0, 7, 8'h01, RND_DATA);
        e = 8'h01;
        for (int k = 0; k < 8; k++) begin
            send_beat(rep(e), 1'b0);
            e = lfsr_f(e);
            check_value("t6_busy", 64'(cmp_busy_o), (k < 7) ? 64'd1 : 64'd0);
        end
        arm(32'h8000, 7, 0, 7, 8'h5A, RND_DATA);
        e = 8'h5A;
        for (int k = 0; k < 8; k++) begin
            d = (k == 7) ? (rep(e) ^ 64'h0100_0000_0000_0000) : rep(e);
            send_beat(d, (k == 7));
            if (k < 7) e = lfsr_f(e);
        end
        check_value("t6_busy_last_err", 64'(cmp_busy_o), 64'd0);
`ifdef COMPARE_ERR_CAPTURE_EN
        check_value("t6_err_addr", 64'(err_addr_o), 64'h8038);
        check_value("t6_err_exp", err_exp_o, rep(e));
`endif

        repeat (3) @(negedge clk_i);
        check_value("sb_leftover", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
